// File: rtl/mem_req_issuer.sv
// Memory-stage request issuer: buffers load/store/branch requests from
// execute in a small circular FIFO and issues one per cycle into a
// registered issue slot. It captures load data and drops the younger
// buffered requests when the memory stage resolves a taken branch.
module mem_req_issuer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // Execute-side request handshake
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic        req_read,
  input  logic        req_branch,
  input  logic        req_zero,
  // Issue slot towards the memory stage
  output logic [31:0] Alu_Result,
  output logic [31:0] RD,
  output logic        MW,
  output logic        MR,
  output logic        Branch,
  output logic        Zero,
  // Memory-stage feedback
  input  logic        mem_stall,
  input  logic [31:0] ReadData,
  input  logic        PCsrc,
  // Results
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        read;
    logic        branch;
    logic        zero;
  } req_t;

  // FIFO storage and bookkeeping
  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Issue slot and result registers
  logic [31:0] alu_q, alu_d;
  logic [31:0] rd_q, rd_d;
  logic        mw_q, mw_d;
  logic        mr_q, mr_d;
  logic        br_q, br_d;
  logic        zero_q, zero_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        flush_q, flush_d;

  logic taken;
  logic push;
  logic pop;
  req_t head;
  req_t push_entry;

  // A taken branch is only honoured while the issued branch is actually
  // consumed; it overrides both the pop and any same-cycle push.
  assign req_ready  = rst_n && (count_q < DEPTH_C);
  assign taken      = br_q && !mem_stall && PCsrc;
  assign push       = req_valid && req_ready && !taken;
  assign pop        = !mem_stall && (count_q != '0) && !taken;
  assign head       = mem_q[rd_ptr_q];

  // A request claiming both write and read is kept as a plain store.
  assign push_entry = '{addr:   req_addr,
                        wdata:  req_wdata,
                        write:  req_write,
                        read:   req_read && !req_write,
                        branch: req_branch,
                        zero:   req_zero};

  // FIFO pointer and occupancy next-state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (taken) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Issue slot, load capture and flush next-state.
  always_comb begin
    alu_d  = alu_q;
    rd_d   = rd_q;
    mw_d   = mw_q;
    mr_d   = mr_q;
    br_d   = br_q;
    zero_d = zero_q;
    if (!mem_stall) begin
      // Bubble by default; address and write data keep their last values.
      mw_d   = 1'b0;
      mr_d   = 1'b0;
      br_d   = 1'b0;
      zero_d = 1'b0;
      if (pop) begin
        alu_d  = head.addr;
        rd_d   = head.wdata;
        mw_d   = head.write;
        mr_d   = head.read;
        br_d   = head.branch;
        zero_d = head.zero;
      end
    end
    load_valid_d = mr_q && !mem_stall;
    load_data_d  = load_valid_d ? ReadData : load_data_q;
    flush_d      = taken;
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; emptiness is defined by count/pointers, so stale entries are never observed.
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_q        <= '0;
      rd_q         <= '0;
      mw_q         <= 1'b0;
      mr_q         <= 1'b0;
      br_q         <= 1'b0;
      zero_q       <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_q        <= alu_d;
      rd_q         <= rd_d;
      mw_q         <= mw_d;
      mr_q         <= mr_d;
      br_q         <= br_d;
      zero_q       <= zero_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      flush_q      <= flush_d;
    end
  end

  assign Alu_Result = alu_q;
  assign RD         = rd_q;
  assign MW         = mw_q;
  assign MR         = mr_q;
  assign Branch     = br_q;
  assign Zero       = zero_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign flush      = flush_q;

endmodule

// File: tb/tb_mem_req_issuer.sv
// Self-checking bench for mem_req_issuer: a queue-based reference model
// compared against every output each cycle, plus directed scenarios with
// hand-computed literal expectations.
module tb_mem_req_issuer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_write, req_read, req_branch, req_zero;
  logic [31:0] Alu_Result, RD;
  logic        MW, MR, Branch, Zero;
  logic        mem_stall;
  logic [31:0] ReadData;
  logic        PCsrc;
  logic [31:0] load_data;
  logic        load_valid, flush;

  int n_tests = 0;
  int n_fail  = 0;

  mem_req_issuer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .req_read(req_read),
    .req_branch(req_branch), .req_zero(req_zero),
    .Alu_Result(Alu_Result), .RD(RD), .MW(MW), .MR(MR),
    .Branch(Branch), .Zero(Zero),
    .mem_stall(mem_stall), .ReadData(ReadData), .PCsrc(PCsrc),
    .load_data(load_data), .load_valid(load_valid), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        w, r, b, z;
  } req_t;

  req_t        mq[$];
  req_t        m_slot;
  logic [31:0] m_load_data;
  logic        m_load_valid, m_flush;

  always @(posedge clk) begin
    logic accept, taken;
    req_t nr;
    if (!rst_n) begin
      mq.delete();
      m_slot       = '{addr: 0, wdata: 0, w: 0, r: 0, b: 0, z: 0};
      m_load_data  = 0;
      m_load_valid = 0;
      m_flush      = 0;
    end else begin
      accept       = req_valid && (mq.size() < DEPTH);
      taken        = m_slot.b && !mem_stall && PCsrc;
      m_load_valid = m_slot.r && !mem_stall;
      if (m_load_valid) m_load_data = ReadData;
      m_flush = taken;
      if (!mem_stall) begin
        if (!taken && mq.size() > 0) begin
          m_slot = mq.pop_front();
        end else begin
          m_slot.w = 0; m_slot.r = 0; m_slot.b = 0; m_slot.z = 0;
        end
        if (taken) mq.delete();
      end
      if (accept && !taken) begin
        nr = '{addr: req_addr, wdata: req_wdata, w: req_write,
               r: req_read && !req_write, b: req_branch, z: req_zero};
        mq.push_back(nr);
      end
    end
  end

  // Compare every output against the model shortly after each edge.
  always @(posedge clk) begin
    #1;
    check("req_ready",  req_ready,  rst_n && (mq.size() < DEPTH));
    check("Alu_Result", Alu_Result, m_slot.addr);
    check("RD",         RD,         m_slot.wdata);
    check("MW",         MW,         m_slot.w);
    check("MR",         MR,         m_slot.r);
    check("Branch",     Branch,     m_slot.b);
    check("Zero",       Zero,       m_slot.z);
    check("load_data",  load_data,  m_load_data);
    check("load_valid", load_valid, m_load_valid);
    check("flush",      flush,      m_flush);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic r, input logic b, input logic z);
    req_valid = 1; req_addr = a; req_wdata = d;
    req_write = w; req_read = r; req_branch = b; req_zero = z;
  endtask

  task automatic idle();
    req_valid = 0; req_write = 0; req_read = 0; req_branch = 0; req_zero = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; mem_stall = 0; PCsrc = 0; ReadData = 32'd70;
    drive(32'd9, 32'd99, 1, 0, 0, 0);

    // Reset held 3 cycles with req_valid asserted
    repeat (3) nxt();
    check("rst_ready", req_ready, 0);
    check("rst_MW", MW, 0);
    check("rst_alu", Alu_Result, 0);
    rst_n = 1; idle();
    #1 check("rel_ready", req_ready, 1);
    nxt(); nxt();
    check("rst_nothing_queued", MW, 0);

    // Back-to-back stores
    drive(32'd0, 32'd70, 1, 0, 0, 0); nxt();
    drive(32'd1, 32'd80, 1, 0, 0, 0); nxt();
    idle();
    check("st0_MW", MW, 1); check("st0_alu", Alu_Result, 0); check("st0_RD", RD, 70);
    nxt();
    check("st1_MW", MW, 1); check("st1_alu", Alu_Result, 1); check("st1_RD", RD, 80);
    check("st1_MR", MR, 0);
    nxt();

    // Load
    drive(32'd0, 32'd0, 0, 1, 0, 0); nxt();
    idle(); nxt();
    check("ld_MR", MR, 1);
    nxt();
    check("ld_valid", load_valid, 1); check("ld_data", load_data, 70);
    nxt();
    check("ld_pulse_end", load_valid, 0);

    // Stall / full
    ReadData = 32'd33;
    mem_stall = 1; drive(32'd10, 32'd100, 1, 0, 0, 0); nxt();
    check("stall_ready1", req_ready, 1);
    drive(32'd11, 32'd0, 0, 1, 0, 0); nxt();
    check("stall_full", req_ready, 0);
    drive(32'd12, 32'd120, 1, 0, 0, 0); nxt();
    check("stall_still_full", req_ready, 0);
    check("stall_frozen", MW, 0);
    mem_stall = 0; nxt();
    check("rel_A_alu", Alu_Result, 10); check("rel_A_MW", MW, 1);
    nxt();
    idle();
    check("rel_B_alu", Alu_Result, 11); check("rel_B_MR", MR, 1);
    nxt();
    check("rel_C_alu", Alu_Result, 12); check("rel_C_MW", MW, 1);
    check("rel_ld_data", load_data, 33);
    nxt();
    check("rel_bubble", MW, 0);

    // Taken branch
    drive(32'd5, 32'd0, 0, 0, 1, 1); nxt();
    drive(32'd1, 32'd80, 1, 0, 0, 0); nxt();
    check("br_Branch", Branch, 1);
    drive(32'd0, 32'd0, 0, 1, 0, 0); PCsrc = 1; nxt();
    idle(); PCsrc = 0;
    check("br_flush", flush, 1); check("br_MW", MW, 0); check("br_MR", MR, 0);
    nxt();
    check("br_flush_end", flush, 0); check("br_no_young_MW", MW, 0);
    check("br_no_young_MR", MR, 0);
    nxt();
    check("br_empty_MR", MR, 0);

    // Not-taken branch, stray PCsrc while Branch=0, illegal write+read
    drive(32'd6, 32'd0, 0, 0, 1, 0); nxt();
    drive(32'd7, 32'd77, 1, 1, 0, 0); PCsrc = 1; nxt();
    check("nt_Branch", Branch, 1); check("nt_stray_flush", flush, 0);
    idle(); PCsrc = 0; nxt();
    check("nt_flush", flush, 0); check("ill_alu", Alu_Result, 7);
    check("ill_MW", MW, 1); check("ill_MR", MR, 0);
    nxt();

    // Reset mid-stream
    mem_stall = 1; drive(32'd20, 32'd200, 1, 0, 0, 0); nxt();
    drive(32'd21, 32'd0, 0, 1, 0, 0); nxt();
    idle(); rst_n = 0;
    #1 check("mid_rst_ready", req_ready, 0);
    nxt();
    check("mid_rst_alu", Alu_Result, 0);
    rst_n = 1; mem_stall = 0; nxt();
    check("mid_rst_MW", MW, 0);
    nxt();
    check("mid_rst_MR", MR, 0);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
